// File: rtl/data_cache_ctrl_pkg.sv
// Shared constants and FSM state type for the direct-mapped write-through data cache.
package data_cache_ctrl_pkg;

    localparam int unsigned WORD_SIZE_DEF  = 16;
    localparam int unsigned OFFSET_W       = 2;
    localparam int unsigned LINE_WORDS_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_WRITE,
        ST_WDONE
    } dc_state_e;

endpackage

// File: rtl/data_cache_ctrl_array.sv
// Valid/tag/data storage: combinational read by index, synchronous line and word writes.
module dcache_array
    import data_cache_ctrl_pkg::*;
#(
    parameter int unsigned WORD_SIZE  = 16,
    parameter int unsigned NUM_LINES  = 4,
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned INDEX_W    = 2,
    parameter int unsigned TAG_W      = 12
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [INDEX_W-1:0]               idx_i,
    output logic                             valid_o,
    output logic [TAG_W-1:0]                 tag_o,
    output logic [LINE_WORDS*WORD_SIZE-1:0]  line_o,
    input  logic                             line_we_i,
    input  logic [TAG_W-1:0]                 line_tag_i,
    input  logic [LINE_WORDS*WORD_SIZE-1:0]  line_data_i,
    input  logic                             word_we_i,
    input  logic [OFFSET_W-1:0]              word_off_i,
    input  logic [WORD_SIZE-1:0]             word_data_i
);

    logic [NUM_LINES-1:0]             valid_q;
    logic [TAG_W-1:0]                 tag_q  [NUM_LINES];
    logic [LINE_WORDS*WORD_SIZE-1:0]  data_q [NUM_LINES];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
        end else if (line_we_i) begin
            valid_q[idx_i] <= 1'b1;
        end
    end

    // Tags and data need no reset: every read is qualified by the valid bit.
    always_ff @(posedge clk_i) begin
        if (line_we_i) begin
            tag_q[idx_i]  <= line_tag_i;
            data_q[idx_i] <= line_data_i;
        end else if (word_we_i) begin
            data_q[idx_i][word_off_i*WORD_SIZE +: WORD_SIZE] <= word_data_i;
        end
    end

    assign valid_o = valid_q[idx_i];
    assign tag_o   = tag_q[idx_i];
    assign line_o  = data_q[idx_i];

endmodule

// File: rtl/data_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller with
// read hit/miss counters; FSM and counters live here, storage in dcache_array.
module data_cache_ctrl
    import data_cache_ctrl_pkg::*;
#(
    parameter int unsigned WORD_SIZE  = 16,
    parameter int unsigned NUM_LINES  = 4,
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic                             Clk,
    input  logic                             Reset,
    input  logic                             req_read,
    input  logic                             req_write,
    input  logic [WORD_SIZE-1:0]             req_addr,
    input  logic [WORD_SIZE-1:0]             req_wdata,
    output logic [WORD_SIZE-1:0]             rdata,
    output logic                             stall,
    output logic                             mem_req,
    output logic                             mem_we,
    output logic [WORD_SIZE-1:0]             mem_addr,
    output logic [WORD_SIZE-1:0]             mem_wdata,
    input  logic [LINE_WORDS*WORD_SIZE-1:0]  mem_rdata,
    input  logic                             mem_ready,
    output logic [15:0]                      hit_count,
    output logic [15:0]                      miss_count
);

    localparam int unsigned INDEX_W = $clog2(NUM_LINES);
    localparam int unsigned TAG_W   = WORD_SIZE - INDEX_W - OFFSET_W;
    localparam int unsigned LINE_W  = LINE_WORDS * WORD_SIZE;

    dc_state_e              state_q, state_d;
    logic                   prev_fill_q;
    logic                   mem_req_q, mem_req_d;
    logic                   mem_we_q, mem_we_d;
    logic [WORD_SIZE-1:0]   mem_addr_q, mem_addr_d;
    logic [WORD_SIZE-1:0]   mem_wdata_q, mem_wdata_d;
    logic [15:0]            hit_q, hit_d;
    logic [15:0]            miss_q, miss_d;

    logic [WORD_SIZE-1:0]   lk_addr;
    logic [OFFSET_W-1:0]    lk_off;
    logic [INDEX_W-1:0]     lk_idx;
    logic [TAG_W-1:0]       lk_tag;
    logic                   arr_valid;
    logic [TAG_W-1:0]       arr_tag;
    logic [LINE_W-1:0]      arr_line;
    logic                   hit;
    logic                   xfer_done;
    logic                   stall_c;
    logic                   line_we;
    logic                   word_we;

    // IDLE looks up the live request; FILL/WRITE look up the latched transaction address.
    assign lk_addr   = (state_q == ST_IDLE) ? req_addr : mem_addr_q;
    assign lk_off    = lk_addr[OFFSET_W-1:0];
    assign lk_idx    = lk_addr[OFFSET_W +: INDEX_W];
    assign lk_tag    = lk_addr[WORD_SIZE-1 -: TAG_W];
    assign hit       = arr_valid && (arr_tag == lk_tag);
    assign xfer_done = mem_req_q && mem_ready;

    dcache_array #(
        .WORD_SIZE  (WORD_SIZE),
        .NUM_LINES  (NUM_LINES),
        .LINE_WORDS (LINE_WORDS),
        .INDEX_W    (INDEX_W),
        .TAG_W      (TAG_W)
    ) u_array (
        .clk_i       (Clk),
        .rst_i       (Reset),
        .idx_i       (lk_idx),
        .valid_o     (arr_valid),
        .tag_o       (arr_tag),
        .line_o      (arr_line),
        .line_we_i   (line_we),
        .line_tag_i  (lk_tag),
        .line_data_i (mem_rdata),
        .word_we_i   (word_we),
        .word_off_i  (lk_off),
        .word_data_i (mem_wdata_q)
    );

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        hit_d       = hit_q;
        miss_d      = miss_q;
        stall_c     = 1'b0;
        line_we     = 1'b0;
        word_we     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (req_read) begin
                    if (hit) begin
                        // The replayed load after a fill was already counted as a miss.
                        if (!prev_fill_q) hit_d = hit_q + 16'd1;
                    end else begin
                        stall_c    = 1'b1;
                        state_d    = ST_FILL;
                        mem_req_d  = 1'b1;
                        mem_we_d   = 1'b0;
                        mem_addr_d = {req_addr[WORD_SIZE-1:OFFSET_W], {OFFSET_W{1'b0}}};
                        miss_d     = miss_q + 16'd1;
                    end
                end else if (req_write) begin
                    stall_c     = 1'b1;
                    state_d     = ST_WRITE;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = req_addr;
                    mem_wdata_d = req_wdata;
                end
            end
            ST_FILL: begin
                stall_c = 1'b1;
                if (xfer_done) begin
                    line_we   = 1'b1;
                    mem_req_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            ST_WRITE: begin
                stall_c = 1'b1;
                if (xfer_done) begin
                    word_we   = hit;
                    mem_req_d = 1'b0;
                    state_d   = ST_WDONE;
                end
            end
            ST_WDONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            prev_fill_q <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            hit_q       <= '0;
            miss_q      <= '0;
        end else begin
            state_q     <= state_d;
            prev_fill_q <= (state_q == ST_FILL);
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            hit_q       <= hit_d;
            miss_q      <= miss_d;
        end
    end

    assign stall      = Reset ? 1'b0 : stall_c;
    assign rdata      = Reset ? '0 : arr_line[lk_off*WORD_SIZE +: WORD_SIZE];
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign hit_count  = hit_q;
    assign miss_count = miss_q;

endmodule

// File: tb/tb_data_cache_ctrl.sv
// Directed bench for data_cache_ctrl: backing-memory and cache-contents model,
// per-cycle compare process, and literal pins from hand-worked transactions.
module tb_data_cache_ctrl;

    logic        Clk;
    logic        Reset;
    logic        req_read;
    logic        req_write;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic [15:0] rdata;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic        mem_ready;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    data_cache_ctrl #(
        .WORD_SIZE  (16),
        .NUM_LINES  (4),
        .LINE_WORDS (4)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .req_read   (req_read),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rdata      (rdata),
        .stall      (stall),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_on   = 1'b0;

    // Backing memory: explicit entries, otherwise addr ^ 0xA5A5.
    logic [15:0] mem [logic [15:0]];

    // Cache contents model (what a correct cache must hold), plus expected counters.
    bit          m_valid [4];
    logic [11:0] m_tag   [4];
    logic [15:0] m_data  [4][4];
    logic [15:0] m_hits;
    logic [15:0] m_misses;
    bit          exp_mem_req;

    logic [15:0] last_fill_addr;
    logic [15:0] last_wr_addr;
    logic [15:0] last_wr_data;
    logic        last_wr_we;
    logic        last_detect_stall;
    logic [15:0] got;

    function automatic logic [15:0] mem_rd(input logic [15:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 16'hA5A5;
    endfunction

    function automatic logic [63:0] mem_line(input logic [15:0] base);
        return {mem_rd(base + 16'd3), mem_rd(base + 16'd2), mem_rd(base + 16'd1), mem_rd(base)};
    endfunction

    function automatic bit m_hit(input logic [15:0] a);
        return m_valid[a[3:2]] && (m_tag[a[3:2]] == a[15:4]);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
        m_hits      = '0;
        m_misses    = '0;
        exp_mem_req = 1'b0;
    endtask

    // Driver tasks start and end at posedge+1.
    task automatic do_read(input logic [15:0] a, input int lat, output logic [15:0] data);
        bit          miss;
        logic [15:0] base;
        miss = !m_hit(a);
        base = {a[15:2], 2'b00};
        req_read = 1'b1;
        req_write = 1'b0;
        req_addr = a;
        @(negedge Clk);
        chk("rd_detect_stall", stall, miss);
        last_detect_stall = stall;
        data = rdata;
        @(posedge Clk); #1;
        if (!miss) begin
            m_hits++;
        end else begin
            m_misses++;
            exp_mem_req = 1'b1;
            for (int i = 0; i < lat; i++) begin
                mem_ready = (i == lat - 1);
                mem_rdata = mem_ready ? mem_line(base) : 64'hDEAD_BEEF_DEAD_BEEF;
                @(negedge Clk);
                chk("fill_stall", stall, 1);
                chk("fill_req", mem_req, 1);
                chk("fill_we", mem_we, 0);
                chk("fill_addr", mem_addr, base);
                if (i == 0) last_fill_addr = mem_addr;
                @(posedge Clk); #1;
            end
            mem_ready = 1'b0;
            exp_mem_req = 1'b0;
            m_valid[a[3:2]] = 1'b1;
            m_tag[a[3:2]] = a[15:4];
            for (int k = 0; k < 4; k++) m_data[a[3:2]][k] = mem_rd(base + 16'(k));
            @(negedge Clk);
            chk("replay_stall", stall, 0);
            data = rdata;
            @(posedge Clk); #1;
        end
        req_read = 1'b0;
    endtask

    task automatic do_write(input logic [15:0] a, input logic [15:0] d, input int lat);
        req_write = 1'b1;
        req_read = 1'b0;
        req_addr = a;
        req_wdata = d;
        @(negedge Clk);
        chk("wr_detect_stall", stall, 1);
        @(posedge Clk); #1;
        exp_mem_req = 1'b1;
        for (int i = 0; i < lat; i++) begin
            mem_ready = (i == lat - 1);
            @(negedge Clk);
            chk("wr_stall", stall, 1);
            chk("wr_req", mem_req, 1);
            chk("wr_we", mem_we, 1);
            chk("wr_addr", mem_addr, a);
            chk("wr_wdata", mem_wdata, d);
            last_wr_addr = mem_addr;
            last_wr_data = mem_wdata;
            last_wr_we = mem_we;
            @(posedge Clk); #1;
        end
        mem_ready = 1'b0;
        exp_mem_req = 1'b0;
        mem[a] = d;
        if (m_hit(a)) m_data[a[3:2]][a[1:0]] = d;
        @(negedge Clk);
        chk("wdone_stall", stall, 0);
        @(posedge Clk); #1;
        req_write = 1'b0;
    endtask

    task automatic idle(input int n);
        req_read = 1'b0;
        req_write = 1'b0;
        repeat (n) begin
            @(posedge Clk); #1;
        end
    endtask

    always @(negedge Clk) begin
        if (chk_on) begin
            if (Reset) begin
                chk("rst_stall", stall, 0);
                chk("rst_rdata", rdata, 0);
            end else begin
                chk("hit_count", hit_count, m_hits);
                chk("miss_count", miss_count, m_misses);
                chk("mem_req", mem_req, exp_mem_req);
                if (req_read && !stall && m_hit(req_addr))
                    chk("rdata", rdata, m_data[req_addr[3:2]][req_addr[1:0]]);
            end
        end
    end

    initial begin
        Reset = 1'b1;
        req_read = 1'b0;
        req_write = 1'b0;
        req_addr = '0;
        req_wdata = '0;
        mem_rdata = '0;
        mem_ready = 1'b0;
        mem[16'h0010] = 16'h0001;
        mem[16'h0011] = 16'h0002;
        mem[16'h0012] = 16'h0003;
        mem[16'h0013] = 16'h0004;
        model_clear();
        chk_on = 1'b1;
        repeat (2) @(posedge Clk);
        #1 Reset = 1'b0;
        chk("pin_rst_hits", hit_count, 16'd0);
        chk("pin_rst_misses", miss_count, 16'd0);
        chk("pin_rst_memreq", mem_req, 1'b0);

        // Cold read of 0x0012
        do_read(16'h0012, 3, got);
        chk("pin_fill_addr", last_fill_addr, 16'h0010);
        chk("pin_rd12", got, 16'h0003);
        chk("pin_miss1", miss_count, 16'd1);
        chk("pin_hit0", hit_count, 16'd0);

        do_read(16'h0013, 1, got);
        chk("pin_rd13", got, 16'h0004);
        chk("pin_hit1", hit_count, 16'd1);

        do_write(16'h0011, 16'hBEEF, 2);
        chk("pin_wr_addr", last_wr_addr, 16'h0011);
        chk("pin_wr_data", last_wr_data, 16'hBEEF);
        chk("pin_wr_we", last_wr_we, 1'b1);
        do_read(16'h0011, 1, got);
        chk("pin_rd11", got, 16'hBEEF);
        chk("pin_hit2", hit_count, 16'd2);

        // Conflict on index 0
        do_read(16'h0052, 1, got);
        chk("pin_fill52", last_fill_addr, 16'h0050);
        chk("pin_rd52", got, 16'hA5F7);
        do_read(16'h0012, 2, got);
        chk("pin_rd12_again", got, 16'h0003);
        chk("pin_miss3", miss_count, 16'd3);
        do_read(16'h0011, 1, got);
        chk("pin_rd11_wt", got, 16'hBEEF);

        // Write miss must not allocate
        do_write(16'h0100, 16'h1234, 1);
        do_read(16'h0100, 2, got);
        chk("pin_noalloc", last_detect_stall, 1'b1);
        chk("pin_rd100", got, 16'h1234);
        chk("pin_miss4", miss_count, 16'd4);

        do_read(16'h0024, 1, got);
        do_read(16'h0027, 1, got);
        chk("pin_rd27", got, 16'hA582);

        // Stray mem_ready with no outstanding request
        mem_ready = 1'b1;
        idle(2);
        mem_ready = 1'b0;
        do_read(16'h0027, 1, got);
        chk("pin_hit5", hit_count, 16'd5);

        // Back-to-back store then load of the same word
        do_write(16'h0025, 16'h5A5A, 3);
        do_read(16'h0025, 1, got);
        chk("pin_rd25", got, 16'h5A5A);

        // Reset in the second FILL cycle
        req_read = 1'b1;
        req_addr = 16'h0012;
        @(negedge Clk);
        chk("pre_rst_stall", stall, 1);
        @(posedge Clk); #1;
        m_misses++;
        exp_mem_req = 1'b1;
        @(negedge Clk);
        chk("pre_rst_req", mem_req, 1);
        @(posedge Clk); #1;
        Reset = 1'b1;
        @(posedge Clk); #1;
        Reset = 1'b0;
        req_read = 1'b0;
        model_clear();
        chk("pin_post_rst_req", mem_req, 1'b0);
        chk("pin_post_rst_hits", hit_count, 16'd0);
        chk("pin_post_rst_miss", miss_count, 16'd0);
        do_read(16'h0012, 3, got);
        chk("pin_post_rst_detect", last_detect_stall, 1'b1);
        chk("pin_post_rst_rd", got, 16'h0003);
        chk("pin_post_rst_miss1", miss_count, 16'd1);

        idle(2);
        chk_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
